// File: rtl/zx_ram_arbiter.sv
// zx_ram_arbiter: shares the single SDRAM byte port between the Z80 path (CPU)
// and the tape-to-RAM copy engine (DMA). CPU has priority; DMA wins a contended
// grant after STARVE_MAX consecutive CPU grants made while DMA was waiting.
// Each access: one-cycle mem_rd/mem_we strobe on the first busy cycle, address and
// data held for the whole access, completion on mem_ready or after TIMEOUT busy
// cycles. The matching ack is combinational in the completion cycle.
// Ports:
//   clk_sys, reset (sync, active high)
//   cpu_* / dma_* : level requests, held stable until ack; rdata held between reads
//   mem_*         : sdram controller side (strobes, address, data, ready pulse)
//   busy, dma_owner, timeout_err : status (tape mux select, abort pulse)
module zx_ram_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic [7:0]  dma_rdata,
    output logic        dma_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [7:0]  mem_dout,
    input  logic        mem_ready,
    output logic        busy,
    output logic        dma_owner,
    output logic        timeout_err
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CPU_BUSY, DMA_BUSY} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          we_q, we_d;
    logic          rd_stb_q, rd_stb_d;
    logic          wr_stb_q, wr_stb_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [7:0]    dma_rdata_q, dma_rdata_d;

    logic in_busy, expire, done, grant_cpu, grant_dma;
    logic [7:0] rd_result;

    always_comb begin
        in_busy   = (state_q != IDLE);
        // tmo_q is 0 in the first busy cycle, so this fires in busy cycle TIMEOUT.
        expire    = in_busy && (tmo_q == TW'(TIMEOUT - 1));
        done      = in_busy && (mem_ready || expire);
        grant_dma = (state_q == IDLE) && dma_req &&
                    (!cpu_req || (starve_q == SW'(STARVE_MAX)));
        grant_cpu = (state_q == IDLE) && cpu_req && !grant_dma;
        // A coincident mem_ready beats the timeout.
        rd_result = mem_ready ? mem_dout : 8'hFF;
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        addr_d      = addr_q;
        din_d       = din_q;
        we_d        = we_q;
        rd_stb_d    = 1'b0;
        wr_stb_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;

        if (grant_cpu) begin
            state_d  = CPU_BUSY;
            addr_d   = cpu_addr;
            din_d    = cpu_wdata;
            we_d     = cpu_we;
            rd_stb_d = !cpu_we;
            wr_stb_d = cpu_we;
            tmo_d    = '0;
        end else if (grant_dma) begin
            state_d  = DMA_BUSY;
            addr_d   = dma_addr;
            din_d    = dma_wdata;
            we_d     = dma_we;
            rd_stb_d = !dma_we;
            wr_stb_d = dma_we;
            tmo_d    = '0;
        end else if (done) begin
            state_d = IDLE;
            if (!we_q) begin
                if (state_q == CPU_BUSY) cpu_rdata_d = rd_result;
                else                     dma_rdata_d = rd_result;
            end
        end else if (in_busy) begin
            tmo_d = tmo_q + TW'(1);
        end

        // Only CPU grants that overtake a waiting DMA count toward starvation.
        if (!dma_req || grant_dma) begin
            starve_d = '0;
        end else if (grant_cpu && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            tmo_q       <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            cpu_rdata_q <= 8'hFF;
            dma_rdata_q <= 8'hFF;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            rd_stb_q    <= rd_stb_d;
            wr_stb_q    <= wr_stb_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        cpu_rdata   = cpu_rdata_q;
        dma_rdata   = dma_rdata_q;
        cpu_ack     = (state_q == CPU_BUSY) && done;
        dma_ack     = (state_q == DMA_BUSY) && done;
        mem_addr    = addr_q;
        mem_din     = din_q;
        mem_we      = wr_stb_q;
        mem_rd      = rd_stb_q;
        busy        = in_busy;
        dma_owner   = (state_q == DMA_BUSY);
        timeout_err = expire && !mem_ready;
    end
endmodule

// File: tb/tb_zx_ram_arbiter.sv
`timescale 1ns/1ps
module tb_zx_ram_arbiter;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = '0;
    logic [7:0]  dma_wdata = '0;
    logic [7:0]  dma_rdata;
    logic        dma_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we, mem_rd;
    logic [7:0]  mem_dout = '0;
    logic        mem_ready = 1'b0;
    logic        busy, dma_owner, timeout_err;

    always #5 clk_sys = ~clk_sys;

    zx_ram_arbiter dut (
        .clk_sys(clk_sys), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
        .mem_dout(mem_dout), .mem_ready(mem_ready),
        .busy(busy), .dma_owner(dma_owner), .timeout_err(timeout_err)
    );

    typedef struct { bit own; bit we; logic [15:0] addr; logic [7:0] din; } stb_t;
    typedef struct { bit own; bit tmo; logic [7:0] cpu_rd; logic [7:0] dma_rd; } ack_t;

    stb_t sq[$];
    ack_t aq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   ack_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // SDRAM controller model: answers a strobe with mem_ready in busy cycle resp_lat.
    bit         resp_en = 1'b0;
    int         resp_lat = 3;
    logic [7:0] resp_data = '0;

    initial begin
        forever begin
            @(posedge clk_sys); #1;
            if (resp_en && !reset && (mem_rd || mem_we)) begin
                repeat (resp_lat - 1) begin @(posedge clk_sys); #1; end
                mem_dout  = resp_data;
                mem_ready = 1'b1;
                @(posedge clk_sys); #1;
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT strobes the memory or acks.
    stb_t mon_s;
    ack_t mon_a;
    ack_t pend;
    bit   pend_vld = 1'b0;

    always @(negedge clk_sys) begin
        if (pend_vld) begin
            chk("cpu_rdata", cpu_rdata, pend.cpu_rd);
            chk("dma_rdata", dma_rdata, pend.dma_rd);
            pend_vld = 1'b0;
        end
        if (!reset && (mem_rd || mem_we)) begin
            if (sq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: rd=%0b we=%0b addr=%0h", mem_rd, mem_we, mem_addr);
            end else begin
                mon_s = sq.pop_front();
                chk("strobe_we", mem_we, mon_s.we);
                chk("strobe_rd", mem_rd, !mon_s.we);
                chk("strobe_addr", mem_addr, mon_s.addr);
                if (mon_s.we) chk("strobe_din", mem_din, mon_s.din);
                chk("strobe_owner", dma_owner, mon_s.own);
                chk("strobe_busy", busy, 1);
            end
        end
        if (!reset && (cpu_ack || dma_ack)) begin
            ack_cnt++;
            if (aq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: cpu_ack=%0b dma_ack=%0b", cpu_ack, dma_ack);
            end else begin
                mon_a = aq.pop_front();
                chk("ack_owner", {cpu_ack, dma_ack}, mon_a.own ? 2'b01 : 2'b10);
                chk("ack_timeout_err", timeout_err, mon_a.tmo);
                chk("ack_dma_owner", dma_owner, mon_a.own);
                chk("ack_addr_held", mem_addr, sq.size() == 0 ? mem_addr : mem_addr);
                pend     = mon_a;
                pend_vld = 1'b1;
            end
        end
    end

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_sys);
            if (mem_rd || mem_we) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One directed access; exp_cyc is the busy cycle (1 = strobe cycle) of the ack.
    task automatic access(input bit own, input bit we, input logic [15:0] addr,
                          input logic [7:0] wd, input bit en, input int lat,
                          input logic [7:0] rd, input logic [7:0] ec, input logic [7:0] ed,
                          input bit tmo, input int exp_cyc);
        bit ok;
        int k;
        sq.push_back('{own, we, addr, wd});
        aq.push_back('{own, tmo, ec, ed});
        resp_en   = en;
        resp_lat  = lat;
        resp_data = rd;
        @(posedge clk_sys); #1;
        if (own) begin
            dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1'b1;
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        end
        wait_strobe(ok);
        if (!ok) begin
            n_total++;
            $display("FAIL strobe_wait: no strobe for addr %0h", addr);
            @(posedge clk_sys); #1;
            cpu_req = 1'b0; dma_req = 1'b0;
            return;
        end
        k = 1;
        while (!(own ? dma_ack : cpu_ack) && k < 100) begin
            @(negedge clk_sys);
            k++;
        end
        chk("ack_cycle", k, exp_cyc);
        @(posedge clk_sys); #1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        chk("busy_after_ack", busy, 0);
        chk("owner_after_ack", dma_owner, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int base;
        int n;

        // Reset values
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_acks", {cpu_ack, dma_ack}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dma_owner", dma_owner, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
        chk("rst_dma_rdata", dma_rdata, 8'hFF);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        @(posedge clk_sys); #1;
        reset = 1'b0;

        // CPU read alone, DMA write alone
        access(1'b0, 1'b0, 16'h4000, 8'h00, 1'b1, 3, 8'h3C, 8'h3C, 8'hFF, 1'b0, 3);
        access(1'b1, 1'b1, 16'h4009, 8'hA5, 1'b1, 3, 8'h00, 8'h3C, 8'hFF, 1'b0, 3);

        // Contention: both held; expect C,C,C,C,D twice
        resp_en = 1'b1; resp_lat = 3; resp_data = 8'h77;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                sq.push_back('{1'b1, 1'b1, 16'h5678, 8'h5A});
                aq.push_back('{1'b1, 1'b0, 8'h77, 8'hFF});
            end else begin
                sq.push_back('{1'b0, 1'b0, 16'h1234, 8'h00});
                aq.push_back('{1'b0, 1'b0, 8'h77, 8'hFF});
            end
        end
        @(posedge clk_sys); #1;
        cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
        dma_we = 1'b1; dma_addr = 16'h5678; dma_wdata = 8'h5A;
        base = ack_cnt;
        cpu_req = 1'b1; dma_req = 1'b1;
        n = 0;
        while ((ack_cnt - base) < 10 && n < 400) begin
            @(negedge clk_sys); #1;
            n++;
        end
        chk("contention_acks", ack_cnt - base, 10);
        @(posedge clk_sys); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1 chk("contention_idle", busy, 0);

        // Timeout on a CPU read, then a normal DMA read
        access(1'b0, 1'b0, 16'h0100, 8'h00, 1'b0, 3, 8'h00, 8'hFF, 8'hFF, 1'b1, 63);
        access(1'b1, 1'b0, 16'h4100, 8'h00, 1'b1, 3, 8'h99, 8'hFF, 8'h99, 1'b0, 3);

        // mem_ready coinciding with the timeout cycle wins
        access(1'b0, 1'b0, 16'h0200, 8'h00, 1'b1, 63, 8'h11, 8'h11, 8'h99, 1'b0, 63);

        // Reset during a DMA access, then a stray late mem_ready
        resp_en = 1'b0;
        sq.push_back('{1'b1, 1'b0, 16'h4200, 8'h00});
        @(posedge clk_sys); #1;
        dma_we = 1'b0; dma_addr = 16'h4200; dma_req = 1'b1;
        wait_strobe(ok);
        chk("rst_test_strobe", ok, 1);
        @(posedge clk_sys); #1;
        chk("rst_test_owner_before", dma_owner, 1);
        reset = 1'b1;
        dma_req = 1'b0;
        @(posedge clk_sys); #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_dma_owner", dma_owner, 0);
        chk("midrst_dma_ack", dma_ack, 0);
        chk("midrst_cpu_rdata", cpu_rdata, 8'hFF);
        chk("midrst_dma_rdata", dma_rdata, 8'hFF);
        chk("midrst_mem_addr", mem_addr, 0);
        reset = 1'b0;
        @(posedge clk_sys); #1;
        mem_dout = 8'hEE;
        mem_ready = 1'b1;
        #1 chk("stray_ready_acks", {cpu_ack, dma_ack}, 0);
        @(posedge clk_sys); #1;
        mem_ready = 1'b0;
        chk("stray_ready_rdata", dma_rdata, 8'hFF);
        chk("stray_ready_busy", busy, 0);

        repeat (3) @(posedge clk_sys);
        chk("strobe_queue_empty", sq.size(), 0);
        chk("ack_queue_empty", aq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
